seg_readback_decoder: RTL and testbench

Readback monitor for the signed 3-bit ALU display path: samples the 8-bit seven-segment pattern bus driven toward SEG and waits until the pattern is stable for a programmable number of cycles. It then decodes the pattern back into a two's-complement value, or into an overflow or invalid flag. It keeps saturating event counters and sits beside the display driver on the lab board, so the LCD debug outputs and self-check benches can confirm what the display actually shows.

---
 rtl/seg_readback_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg_readback_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_readback_decoder.sv
// seg_readback_decoder: watches the seven-segment bus of the signed 3-bit
// ALU display, waits for a stable pattern, decodes it back to a
// two's-complement value (or overflow / invalid) and keeps saturating
// event counters.
module seg_readback_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [7:0]       seg_in,
    output logic [2:0]       value,
    output logic             value_valid,
    output logic             ovf,
    output logic             invalid,
    output logic             busy,
    output logic [7:0]       last_seg,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] CNT_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] CNT_LAST = STAB_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        ref_seg, ref_nxt;
    logic [STAB_W-1:0] cnt, cnt_nxt;
    logic              do_capture;
    logic [2:0]        dec_value;
    logic              dec_ovf;
    logic              dec_invalid;

    // Next-state logic: track the candidate pattern and its run length.
    always_comb begin
        state_nxt  = state;
        ref_nxt    = ref_seg;
        cnt_nxt    = cnt;
        do_capture = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            ref_nxt   = '0;
            cnt_nxt   = '0;
        end else if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    ref_nxt   = seg_in;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (CNT_ONE == CNT_LAST) ? CAPTURE : SETTLE;
                end
                SETTLE: begin
                    if (seg_in != ref_seg) begin
                        ref_nxt   = seg_in;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (CNT_ONE == CNT_LAST) ? CAPTURE : SETTLE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (cnt_nxt == CNT_LAST) begin
                            state_nxt = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    do_capture = 1'b1;
                    state_nxt  = HOLD;
                end
                HOLD: begin
                    if (seg_in != last_seg) begin
                        ref_nxt   = seg_in;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (CNT_ONE == CNT_LAST) ? CAPTURE : SETTLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Pattern-to-value decode of the settled candidate.
    always_comb begin
        dec_value   = '0;
        dec_ovf     = 1'b0;
        dec_invalid = 1'b0;
        case (ref_seg)
            8'b0011_1111: dec_value = 3'b000;
            8'b0000_0110: dec_value = 3'b001;
            8'b0101_1011: dec_value = 3'b010;
            8'b0100_1111: dec_value = 3'b011;
            8'b1000_0110: dec_value = 3'b111;
            8'b1101_1011: dec_value = 3'b110;
            8'b1100_1111: dec_value = 3'b101;
            8'b1110_0110: dec_value = 3'b100;
            8'b1011_1111: dec_ovf   = 1'b1;
            default:      dec_invalid = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Candidate pattern and equal-sample count.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            ref_seg <= '0;
            cnt     <= '0;
        end else begin
            ref_seg <= ref_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Result outputs and saturating event counters.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            value        <= '0;
            value_valid  <= 1'b0;
            ovf          <= 1'b0;
            invalid      <= 1'b0;
            last_seg     <= '0;
            sample_count <= '0;
            ovf_count    <= '0;
            err_count    <= '0;
        end else begin
            value_valid <= 1'b0;
            if (clear) begin
                value        <= '0;
                ovf          <= 1'b0;
                invalid      <= 1'b0;
                last_seg     <= '0;
                sample_count <= '0;
                ovf_count    <= '0;
                err_count    <= '0;
            end else if (do_capture) begin
                value       <= dec_value;
                ovf         <= dec_ovf;
                invalid     <= dec_invalid;
                last_seg    <= ref_seg;
                value_valid <= 1'b1;
                if (sample_count != '1) begin
                    sample_count <= sample_count + CNT_W'(1);
                end
                if (dec_ovf && (ovf_count != '1)) begin
                    ovf_count <= ovf_count + CNT_W'(1);
                end
                if (dec_invalid && (err_count != '1)) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state == SETTLE) || (state == CAPTURE);

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Directed bench for seg_readback_decoder: table of decode vectors plus
// hand-written glitch, hold, enable, saturation, clear and reset sequences.
module tb_seg_readback_decoder;

    localparam int unsigned S  = 4;
    localparam int unsigned CW = 8;

    logic          clk_2;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic [7:0]    seg_in;
    logic [2:0]    value;
    logic          value_valid;
    logic          ovf;
    logic          invalid;
    logic          busy;
    logic [7:0]    last_seg;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] ovf_count;
    logic [CW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] seg;
        logic [2:0] val;
        logic       ovf;
        logic       inv;
        logic [7:0] sc;
        logic [7:0] oc;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[14];

    seg_readback_decoder #(
        .STABLE_CYCLES(S),
        .CNT_W(CW)
    ) dut (
        .clk_2(clk_2),
        .reset_n(reset_n),
        .enable(enable),
        .clear(clear),
        .seg_in(seg_in),
        .value(value),
        .value_valid(value_valid),
        .ovf(ovf),
        .invalid(invalid),
        .busy(busy),
        .last_seg(last_seg),
        .sample_count(sample_count),
        .ovf_count(ovf_count),
        .err_count(err_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // Drive a pattern and wait for its capture pulse, checking latency.
    task automatic capture(input logic [7:0] p, input int exp_ticks, input string tag);
        int n;
        seg_in = p;
        tick();
        n = 1;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " pulse_low"}, 32'(value_valid), 32'd0);
        while (!value_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_ticks));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " value"}, 32'(value), 32'd0);
        check({tag, " value_valid"}, 32'(value_valid), 32'd0);
        check({tag, " ovf"}, 32'(ovf), 32'd0);
        check({tag, " invalid"}, 32'(invalid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " last_seg"}, 32'(last_seg), 32'd0);
        check({tag, " sample_count"}, 32'(sample_count), 32'd0);
        check({tag, " ovf_count"}, 32'(ovf_count), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{8'b0101_1011, 3'b010, 1'b0, 1'b0, 8'd1,  8'd0, 8'd0};
        vecs[1]  = '{8'b0011_1111, 3'b000, 1'b0, 1'b0, 8'd2,  8'd0, 8'd0};
        vecs[2]  = '{8'b0000_0110, 3'b001, 1'b0, 1'b0, 8'd3,  8'd0, 8'd0};
        vecs[3]  = '{8'b0101_1011, 3'b010, 1'b0, 1'b0, 8'd4,  8'd0, 8'd0};
        vecs[4]  = '{8'b0100_1111, 3'b011, 1'b0, 1'b0, 8'd5,  8'd0, 8'd0};
        vecs[5]  = '{8'b1000_0110, 3'b111, 1'b0, 1'b0, 8'd6,  8'd0, 8'd0};
        vecs[6]  = '{8'b1101_1011, 3'b110, 1'b0, 1'b0, 8'd7,  8'd0, 8'd0};
        vecs[7]  = '{8'b1100_1111, 3'b101, 1'b0, 1'b0, 8'd8,  8'd0, 8'd0};
        vecs[8]  = '{8'b1110_0110, 3'b100, 1'b0, 1'b0, 8'd9,  8'd0, 8'd0};
        vecs[9]  = '{8'b1011_1111, 3'b000, 1'b1, 1'b0, 8'd10, 8'd1, 8'd0};
        vecs[10] = '{8'b0101_0101, 3'b000, 1'b0, 1'b1, 8'd11, 8'd1, 8'd1};
        vecs[11] = '{8'b1111_1111, 3'b000, 1'b0, 1'b1, 8'd12, 8'd1, 8'd2};
        vecs[12] = '{8'b0000_0000, 3'b000, 1'b0, 1'b1, 8'd13, 8'd1, 8'd3};
        vecs[13] = '{8'b0000_0111, 3'b000, 1'b0, 1'b1, 8'd14, 8'd1, 8'd4};

        reset_n = 1'b1;
        enable  = 1'b0;
        clear   = 1'b0;
        seg_in  = '0;
        #1 reset_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Table: each pattern arrives the cycle after the previous capture.
        enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            capture(vecs[i].seg, S + 1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d value", i), 32'(value), 32'(vecs[i].val));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            check($sformatf("vec%0d invalid", i), 32'(invalid), 32'(vecs[i].inv));
            check($sformatf("vec%0d last_seg", i), 32'(last_seg), 32'(vecs[i].seg));
            check($sformatf("vec%0d sample_count", i), 32'(sample_count), 32'(vecs[i].sc));
            check($sformatf("vec%0d ovf_count", i), 32'(ovf_count), 32'(vecs[i].oc));
            check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].ec));
        end

        // Glitch: 3 good samples, one glitch sample, then the good pattern again.
        pulses = 0;
        seg_in = 8'b0000_0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (value_valid) pulses++;
        end
        seg_in = 8'b0011_1111;
        tick();
        if (value_valid) pulses++;
        check("glitch no_early_pulse", 32'(pulses), 32'd0);
        capture(8'b0000_0110, S + 1, "glitch");
        check("glitch value", 32'(value), 32'd1);
        check("glitch last_seg", 32'(last_seg), 32'h06);
        check("glitch sample_count", 32'(sample_count), 32'd15);

        // Unchanged pattern in HOLD is never recaptured.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (value_valid) pulses++;
        end
        check("hold no_recapture", 32'(pulses), 32'd0);
        check("hold sample_count", 32'(sample_count), 32'd15);

        // enable dropped in HOLD parks the monitor, results hold.
        enable = 1'b0;
        tick();
        check("park busy", 32'(busy), 32'd0);
        check("park value", 32'(value), 32'd1);
        check("park value_valid", 32'(value_valid), 32'd0);
        enable = 1'b1;
        capture(8'b0000_0110, S + 1, "enable_rise");
        check("enable_rise sample_count", 32'(sample_count), 32'd16);

        // enable dropped mid-SETTLE discards the pending capture.
        seg_in = 8'b0100_1111;
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("settle_drop busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (value_valid) pulses++;
        end
        check("settle_drop no_pulse", 32'(pulses), 32'd0);
        check("settle_drop sample_count", 32'(sample_count), 32'd16);
        check("settle_drop value", 32'(value), 32'd1);

        // Saturation: far more captures than needed to reach 255.
        enable = 1'b1;
        for (int i = 0; i < 260; i++) begin
            capture((i % 2 == 0) ? 8'b0011_1111 : 8'b0000_0110, S + 1, "sat");
        end
        check("sat sample_count", 32'(sample_count), 32'd255);
        check("sat ovf_count", 32'(ovf_count), 32'd1);
        check("sat err_count", 32'(err_count), 32'd4);
        check("sat value", 32'(value), 32'd1);

        // clear on the CAPTURE edge wins: no pulse, no increment.
        seg_in = 8'b0100_1111;
        for (int i = 0; i < S; i++) tick();
        check("clear pre busy", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_all_zero("clear");
        capture(8'b0100_1111, S + 1, "post_clear");
        check("post_clear value", 32'(value), 32'd3);
        check("post_clear sample_count", 32'(sample_count), 32'd1);

        // Asynchronous reset mid-SETTLE.
        seg_in = 8'b1110_0110;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        reset_n = 1'b1;
        capture(8'b1110_0110, S + 1, "post_reset");
        check("post_reset value", 32'(value), 32'd4);
        check("post_reset sample_count", 32'(sample_count), 32'd1);
        check("post_reset last_seg", 32'(last_seg), 32'hE6);
        tick();
        check("post_reset pulse_end", 32'(value_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
